rob_param: RTL and testbench

Parametrised reorder buffer for the Tomasulo core. Allocates a tag to each dispatched instruction and captures results from multiple common-data-bus (CDB) ports. Retires results in program order to the register bank write port. Adds same-cycle operand forwarding to the reservation stations and flushes all younger entries when a mispredicted branch retires.

---
 rtl/rob_param.sv | 171 +++++++++++++++++
 tb/tb_rob_param.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param.sv
// Parametrised reorder buffer: tag allocation, multi-port CDB capture,
// operand forwarding, in-order retirement and mispredict flush.
module rob_param #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int NUM_CDB = 2,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                      clk1,
  input  logic                      rst_n,
  input  logic                      alloc_valid,
  input  logic [REG_W-1:0]          alloc_dest,
  input  logic                      alloc_is_br,
  output logic                      alloc_ready,
  output logic [TAG_W-1:0]          alloc_tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  input  logic [NUM_CDB-1:0]        cdb_mispredict,
  input  logic [TAG_W-1:0]          lk0_tag,
  input  logic [TAG_W-1:0]          lk1_tag,
  output logic                      lk0_ready,
  output logic                      lk1_ready,
  output logic [DATA_W-1:0]         lk0_data,
  output logic [DATA_W-1:0]         lk1_data,
  output logic                      commit_valid,
  output logic [REG_W-1:0]          commit_dest,
  output logic [DATA_W-1:0]         commit_data,
  output logic [TAG_W-1:0]          commit_tag,
  output logic                      flush,
  output logic [TAG_W:0]            count,
  output logic                      full,
  output logic                      empty
);

  localparam logic [TAG_W:0] ONE   = 1;
  localparam logic [TAG_W:0] DEP_C = DEPTH[TAG_W:0];

  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [DEPTH-1:0]             done_q, done_d;
  logic [DEPTH-1:0]             is_br_q, is_br_d;
  logic [DEPTH-1:0]             mispred_q, mispred_d;
  logic [DEPTH-1:0][REG_W-1:0]  dest_q, dest_d;
  logic [DEPTH-1:0][DATA_W-1:0] value_q, value_d;
  logic [TAG_W:0]               head_q, head_d;
  logic [TAG_W:0]               tail_q, tail_d;
  logic                         commit_valid_q, commit_valid_d;
  logic [REG_W-1:0]             commit_dest_q, commit_dest_d;
  logic [DATA_W-1:0]            commit_data_q, commit_data_d;
  logic [TAG_W-1:0]             commit_tag_q, commit_tag_d;
  logic                         flush_q, flush_d;
  logic [TAG_W-1:0]             hidx, tidx;

  assign hidx         = head_q[TAG_W-1:0];
  assign tidx         = tail_q[TAG_W-1:0];
  assign count        = tail_q - head_q;
  assign full         = (count == DEP_C);
  assign empty        = (count == '0);
  assign alloc_ready  = !full && !flush_q;
  assign alloc_tag    = tidx;
  assign commit_valid = commit_valid_q;
  assign commit_dest  = commit_dest_q;
  assign commit_data  = commit_data_q;
  assign commit_tag   = commit_tag_q;
  assign flush        = flush_q;

  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    is_br_d        = is_br_q;
    mispred_d      = mispred_q;
    dest_d         = dest_q;
    value_d        = value_q;
    head_d         = head_q;
    tail_d         = tail_q;
    commit_valid_d = 1'b0;
    commit_dest_d  = commit_dest_q;
    commit_data_d  = commit_data_q;
    commit_tag_d   = commit_tag_q;
    flush_d        = 1'b0;
    if (alloc_valid && alloc_ready) begin
      busy_d[tidx]    = 1'b1;
      done_d[tidx]    = 1'b0;
      mispred_d[tidx] = 1'b0;
      is_br_d[tidx]   = alloc_is_br;
      dest_d[tidx]    = alloc_dest;
      tail_d          = tail_q + ONE;
    end
    // Descending scan so the lowest-index port is applied last and wins.
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] &&
          busy_q[cdb_tag[i*TAG_W +: TAG_W]] &&
          !done_q[cdb_tag[i*TAG_W +: TAG_W]]) begin
        done_d[cdb_tag[i*TAG_W +: TAG_W]]    = 1'b1;
        value_d[cdb_tag[i*TAG_W +: TAG_W]]   =
          cdb_data[i*DATA_W +: DATA_W];
        mispred_d[cdb_tag[i*TAG_W +: TAG_W]] =
          is_br_q[cdb_tag[i*TAG_W +: TAG_W]] & cdb_mispredict[i];
      end
    end
    if (busy_q[hidx] && done_q[hidx]) begin
      busy_d[hidx]    = 1'b0;
      done_d[hidx]    = 1'b0;
      mispred_d[hidx] = 1'b0;
      head_d          = head_q + ONE;
      if (mispred_q[hidx]) begin
        flush_d   = 1'b1;
        busy_d    = '0;
        done_d    = '0;
        mispred_d = '0;
        tail_d    = head_q + ONE;
      end else if (!is_br_q[hidx]) begin
        commit_valid_d = 1'b1;
        commit_dest_d  = dest_q[hidx];
        commit_data_d  = value_q[hidx];
        commit_tag_d   = hidx;
      end
    end
  end

  always_comb begin
    lk0_ready = busy_q[lk0_tag] & done_q[lk0_tag];
    lk0_data  = lk0_ready ? value_q[lk0_tag] : '0;
    lk1_ready = busy_q[lk1_tag] & done_q[lk1_tag];
    lk1_data  = lk1_ready ? value_q[lk1_tag] : '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && cdb_tag[i*TAG_W +: TAG_W] == lk0_tag) begin
        lk0_ready = 1'b1;
        lk0_data  = cdb_data[i*DATA_W +: DATA_W];
      end
      if (cdb_valid[i] && cdb_tag[i*TAG_W +: TAG_W] == lk1_tag) begin
        lk1_ready = 1'b1;
        lk1_data  = cdb_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      busy_q         <= '0;
      done_q         <= '0;
      is_br_q        <= '0;
      mispred_q      <= '0;
      dest_q         <= '0;
      value_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_dest_q  <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
      flush_q        <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      is_br_q        <= is_br_d;
      mispred_q      <= mispred_d;
      dest_q         <= dest_d;
      value_q        <= value_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      commit_valid_q <= commit_valid_d;
      commit_dest_q  <= commit_dest_d;
      commit_data_q  <= commit_data_d;
      commit_tag_q   <= commit_tag_d;
      flush_q        <= flush_d;
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param: expected retirements queued at stimulus
// time, compared by a commit monitor.
module tb_rob_param;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int RW    = 4;
  localparam int NC    = 2;
  localparam int TW    = 3;

  typedef struct {
    logic [RW-1:0] dest;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  logic             clk1 = 1'b0;
  logic             rst_n;
  logic             alloc_valid;
  logic [RW-1:0]    alloc_dest;
  logic             alloc_is_br;
  logic             alloc_ready;
  logic [TW-1:0]    alloc_tag;
  logic [NC-1:0]    cdb_valid;
  logic [NC*TW-1:0] cdb_tag;
  logic [NC*DW-1:0] cdb_data;
  logic [NC-1:0]    cdb_mispredict;
  logic [TW-1:0]    lk0_tag, lk1_tag;
  logic             lk0_ready, lk1_ready;
  logic [DW-1:0]    lk0_data, lk1_data;
  logic             commit_valid;
  logic [RW-1:0]    commit_dest;
  logic [DW-1:0]    commit_data;
  logic [TW-1:0]    commit_tag;
  logic             flush;
  logic [TW:0]      count;
  logic             full, empty;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  rob_param #(.DEPTH(DEPTH), .DATA_W(DW), .REG_W(RW), .NUM_CDB(NC)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_is_br(alloc_is_br), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict),
    .lk0_tag(lk0_tag), .lk1_tag(lk1_tag),
    .lk0_ready(lk0_ready), .lk1_ready(lk1_ready),
    .lk0_data(lk0_data), .lk1_data(lk1_data),
    .commit_valid(commit_valid), .commit_dest(commit_dest),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .flush(flush), .count(count), .full(full), .empty(empty)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [RW-1:0] d, input logic [DW-1:0] v,
                      input logic [TW-1:0] t);
    exp_t e;
    e.dest = d;
    e.data = v;
    e.tag  = t;
    sb.push_back(e);
  endtask

  task automatic idle_in();
    alloc_valid    = 1'b0;
    alloc_dest     = '0;
    alloc_is_br    = 1'b0;
    cdb_valid      = '0;
    cdb_tag        = '0;
    cdb_data       = '0;
    cdb_mispredict = '0;
  endtask

  task automatic step();
    @(negedge clk1);
    idle_in();
  endtask

  task automatic alloc(input logic [RW-1:0] d, input logic br);
    alloc_valid = 1'b1;
    alloc_dest  = d;
    alloc_is_br = br;
    step();
  endtask

  task automatic cdb_set(input int p, input logic [TW-1:0] t,
                         input logic [DW-1:0] v, input logic mp);
    cdb_valid[p]         = 1'b1;
    cdb_tag[p*TW +: TW]  = t;
    cdb_data[p*DW +: DW] = v;
    cdb_mispredict[p]    = mp;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check(tag, sb.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk1);
      #1;
      if (commit_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("commit_extra", commit_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("commit_dest", commit_dest, e.dest);
          check("commit_data", commit_data, e.data);
          check("commit_tag", commit_tag, e.tag);
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    lk0_tag = '0;
    lk1_tag = '0;
    idle_in();
    #2;
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 0);
    check("rst_ready", alloc_ready, 1'b1);
    check("rst_full", full, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // mid-stream reset with 5 entries busy and a commit in flight
    for (int i = 0; i < 6; i++) alloc(RW'(i + 1), 1'b0);
    check("ms_count6", count, 6);
    cdb_set(0, 3'd0, 16'h0042, 1'b0);
    push(4'd1, 16'h0042, 3'd0);
    step();
    step();
    check("ms_cv_pre", commit_valid, 1'b1);
    check("ms_count5", count, 5);
    #2 rst_n = 1'b0;
    #1;
    check("ms_empty", empty, 1'b1);
    check("ms_count", count, 0);
    check("ms_tag", alloc_tag, 0);
    check("ms_cv", commit_valid, 1'b0);
    check("ms_flush", flush, 1'b0);
    check("ms_cdest", commit_dest, 0);
    step();
    rst_n = 1'b1;
    cdb_set(0, 3'd1, 16'h0055, 1'b0);
    cdb_set(1, 3'd2, 16'h0066, 1'b0);
    step();
    repeat (3) step();
    check("ms_post_empty", empty, 1'b1);
    drain("ms_drain");

    // out-of-order completion
    do_reset();
    alloc(4'd1, 1'b0);
    alloc(4'd2, 1'b0);
    alloc(4'd3, 1'b0);
    push(4'd1, 16'h00BB, 3'd0);
    push(4'd2, 16'h00CC, 3'd1);
    push(4'd3, 16'h00AA, 3'd2);
    check("ooo_count", count, 3);
    cdb_set(0, 3'd2, 16'h00AA, 1'b0);
    step();
    cdb_set(1, 3'd0, 16'h00BB, 1'b0);
    step();
    cdb_set(0, 3'd1, 16'h00CC, 1'b0);
    step();
    check("ooo_cv1", commit_valid, 1'b1);
    step();
    check("ooo_cv2", commit_valid, 1'b1);
    step();
    check("ooo_cv3", commit_valid, 1'b1);
    drain("ooo_drain");
    check("ooo_empty", empty, 1'b1);

    // full and wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(RW'(i + 8), 1'b0);
    check("full_full", full, 1'b1);
    check("full_ready", alloc_ready, 1'b0);
    check("full_count", count, 8);
    alloc(4'd3, 1'b0);
    check("full_ninth", count, 8);
    cdb_set(0, 3'd0, 16'h0100, 1'b0);
    push(4'd8, 16'h0100, 3'd0);
    step();
    step();
    check("wrap_ready", alloc_ready, 1'b1);
    check("wrap_tag", alloc_tag, 0);
    check("wrap_count", count, 7);
    alloc(4'd5, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      cdb_set(i % 2, TW'(i), DW'(16'h0200 + i), 1'b0);
      push(RW'(i + 8), DW'(16'h0200 + i), TW'(i));
      step();
    end
    cdb_set(1, 3'd0, 16'h0300, 1'b0);
    push(4'd5, 16'h0300, 3'd0);
    step();
    drain("wrap_drain");
    check("wrap_empty", empty, 1'b1);

    // mispredict flush
    do_reset();
    alloc(4'd0, 1'b1);
    alloc(4'd4, 1'b0);
    alloc(4'd5, 1'b0);
    cdb_set(0, 3'd1, 16'h0011, 1'b0);
    step();
    cdb_set(1, 3'd0, 16'h0000, 1'b1);
    step();
    step();
    check("mp_flush", flush, 1'b1);
    check("mp_ready", alloc_ready, 1'b0);
    check("mp_count", count, 0);
    check("mp_cv", commit_valid, 1'b0);
    step();
    check("mp_flush_end", flush, 1'b0);
    check("mp_ready2", alloc_ready, 1'b1);
    check("mp_tag", alloc_tag, 1);
    repeat (3) step();
    check("mp_empty", empty, 1'b1);

    // CDB priority and lookup forwarding
    do_reset();
    for (int i = 0; i < 5; i++) alloc(RW'(i + 1), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cdb_set(0, TW'(i), DW'(16'h0A00 + i), 1'b0);
      push(RW'(i + 1), DW'(16'h0A00 + i), TW'(i));
      step();
    end
    lk1_tag = 3'd3;
    cdb_set(0, 3'd3, 16'd5, 1'b0);
    cdb_set(1, 3'd3, 16'd9, 1'b0);
    push(4'd4, 16'd5, 3'd3);
    #1;
    check("pri_lk_rdy", lk1_ready, 1'b1);
    check("pri_lk_data", lk1_data, 5);
    step();
    lk0_tag = 3'd4;
    #1;
    check("fwd_pre_rdy", lk0_ready, 1'b0);
    check("fwd_pre_data", lk0_data, 0);
    cdb_set(1, 3'd4, 16'h0007, 1'b0);
    push(4'd5, 16'h0007, 3'd4);
    #1;
    check("fwd_rdy", lk0_ready, 1'b1);
    check("fwd_data", lk0_data, 16'h0007);
    @(posedge clk1);
    #2;
    idle_in();
    #1;
    check("fwd_st_rdy", lk0_ready, 1'b1);
    check("fwd_st_data", lk0_data, 16'h0007);
    drain("pri_drain");
    check("pri_empty", empty, 1'b1);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
